// File: rtl/pwl_segment_lookup.sv
// ============================================================================
// Module   : pwl_segment_lookup
// Purpose  : Piecewise-linear segment search over programmable breakpoints,
//            returning slope/offset coefficients for an IEEE-754 operand.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pwl_segment_lookup #(
  parameter int          NSEG  = 9,
  parameter int          SEG_W = 4,
  parameter logic [31:0] ONE   = 32'h3F800000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      factor_a,
  output logic [31:0]      factor_b,
  output logic [SEG_W-1:0] seg_idx,
  output logic             neg,
  output logic             nan,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [SEG_W-1:0] cfg_addr,
  input  logic [31:0]      cfg_data,
  output logic             cfg_err
);

  localparam int               NENT     = NSEG - 1;
  localparam logic [SEG_W-1:0] LAST_IDX = SEG_W'(NSEG - 2);
  localparam logic [SEG_W-1:0] SAT_SEG  = SEG_W'(NSEG - 1);

  localparam logic [1:0] SEL_BP   = 2'd0;
  localparam logic [1:0] SEL_A    = 2'd1;
  localparam logic [1:0] SEL_BPOS = 2'd2;
  localparam logic [1:0] SEL_BNEG = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Breakpoints only ever take part in a magnitude compare, so the sign bit is not stored.
  logic [30:0] bp_tab   [NENT];
  logic [31:0] a_tab    [NENT];
  logic [31:0] bpos_tab [NENT];
  logic [31:0] bneg_tab [NENT];

  logic [30:0]      mag;
  logic             neg_q;
  logic             nan_q;
  logic [SEG_W-1:0] idx;

  logic             accept;
  logic             hit;
  logic             last;
  logic             scan_end;
  logic             out_fire;
  logic             cfg_ok;

  logic [SEG_W-1:0] res_seg;
  logic [31:0]      res_a;
  logic [31:0]      res_b;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign hit      = (mag < bp_tab[idx]);
  assign last     = (idx == LAST_IDX);
  assign scan_end = (state == SCAN) & (nan_q | hit | last);
  assign out_fire = out_valid & out_ready;
  // A pending input always wins over a table write in the same cycle.
  assign cfg_ok   = cfg_we & (state == IDLE) & ~in_valid & (cfg_addr <= LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = SCAN;
      SCAN:    if (scan_end) state_nxt = DONE;
      DONE:    if (out_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag   <= '0;
      neg_q <= 1'b0;
      nan_q <= 1'b0;
      idx   <= '0;
    end else if (accept) begin
      mag   <= x_in[30:0];
      neg_q <= x_in[31] & (|x_in[30:0]);
      nan_q <= (&x_in[30:23]) & (|x_in[22:0]);
      idx   <= '0;
    end else if ((state == SCAN) && !scan_end) begin
      idx   <= idx + 1'b1;
    end
  end

  // When the scan ends without a hit, idx sits on the last breakpoint: saturation.
  always_comb begin
    res_seg = SAT_SEG;
    res_a   = '0;
    res_b   = '0;
    if (!nan_q) begin
      if (hit) begin
        res_seg = idx;
        res_a   = a_tab[idx];
        res_b   = neg_q ? bneg_tab[idx] : bpos_tab[idx];
      end else begin
        res_b   = neg_q ? 32'h0 : ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      factor_a  <= '0;
      factor_b  <= '0;
      seg_idx   <= '0;
      neg       <= 1'b0;
      nan       <= 1'b0;
    end else if (scan_end) begin
      out_valid <= 1'b1;
      factor_a  <= res_a;
      factor_b  <= res_b;
      seg_idx   <= res_seg;
      neg       <= neg_q;
      nan       <= nan_q;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we & ~cfg_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NENT; i++) begin
        bp_tab[i]   <= '0;
        a_tab[i]    <= '0;
        bpos_tab[i] <= '0;
        bneg_tab[i] <= '0;
      end
    end else if (cfg_ok) begin
      case (cfg_sel)
        SEL_BP:   bp_tab[cfg_addr]   <= cfg_data[30:0];
        SEL_A:    a_tab[cfg_addr]    <= cfg_data;
        SEL_BPOS: bpos_tab[cfg_addr] <= cfg_data;
        SEL_BNEG: bneg_tab[cfg_addr] <= cfg_data;
        default:  ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwl_segment_lookup.sv
// ============================================================================
// Module   : tb_pwl_segment_lookup
// Purpose  : Self-checking bench for pwl_segment_lookup with NSEG = 4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pwl_segment_lookup;

  localparam int          NSEG  = 4;
  localparam int          SEG_W = 2;
  localparam logic [31:0] ONE   = 32'h3F800000;

  localparam logic [31:0] BP0 = 32'h3F800000, BP1 = 32'h40133333, BP2 = 32'h40A00000;
  localparam logic [31:0] A0  = 32'h3E000001, A1  = 32'h3E000002, A2  = 32'h3E000003;
  localparam logic [31:0] P0  = 32'h3F000010, P1  = 32'h3F000011, P2  = 32'h3F000012;
  localparam logic [31:0] N0  = 32'hBF000020, N1  = 32'hBF000021, N2  = 32'hBF000022;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      x_in;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      factor_a;
  logic [31:0]      factor_b;
  logic [SEG_W-1:0] seg_idx;
  logic             neg;
  logic             nan;
  logic             cfg_we;
  logic [1:0]       cfg_sel;
  logic [SEG_W-1:0] cfg_addr;
  logic [31:0]      cfg_data;
  logic             cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Model copy of the tables, only updated by writes the bench expects to be accepted.
  logic [31:0] m_bp [NSEG-1];
  logic [31:0] m_a  [NSEG-1];
  logic [31:0] m_bpos [NSEG-1];
  logic [31:0] m_bneg [NSEG-1];

  typedef struct {
    logic [31:0] x;
    logic [1:0]  seg;
    logic [31:0] a;
    logic [31:0] b;
    logic        neg;
    logic        nan;
    int          lat;
  } vec_t;

  vec_t vecs [8];

  pwl_segment_lookup #(.NSEG(NSEG), .SEG_W(SEG_W), .ONE(ONE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .factor_a(factor_a), .factor_b(factor_b), .seg_idx(seg_idx),
    .neg(neg), .nan(nan),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // First breakpoint strictly above the magnitude wins; none above means saturation.
  function automatic vec_t model(input logic [31:0] x);
    vec_t v;
    logic [31:0] bpi;
    logic found;
    v.x   = x;
    v.nan = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    v.neg = x[31] && (x[30:0] != 0);
    v.seg = 2'(NSEG - 1);
    v.lat = NSEG - 1;
    v.a   = 32'h0;
    v.b   = 32'h0;
    found = 1'b0;
    if (v.nan) begin
      v.lat = 1;
    end else begin
      for (int i = 0; i < NSEG - 1; i++) begin
        bpi = m_bp[i];
        if (!found && (x[30:0] < bpi[30:0])) begin
          found = 1'b1;
          v.seg = 2'(i);
          v.lat = i + 1;
        end
      end
      if (found) begin
        v.a = m_a[v.seg];
        v.b = v.neg ? m_bneg[v.seg] : m_bpos[v.seg];
      end else begin
        v.b = v.neg ? 32'h0 : ONE;
      end
    end
    return v;
  endfunction

  task automatic cfg_write(input logic [1:0] sel, input logic [SEG_W-1:0] addr,
                           input logic [31:0] data, input logic exp_err);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_err_write", {31'b0, cfg_err}, {31'b0, exp_err});
    if (!exp_err) begin
      case (sel)
        2'd0: m_bp[addr]   = data;
        2'd1: m_a[addr]    = data;
        2'd2: m_bpos[addr] = data;
        default: m_bneg[addr] = data;
      endcase
    end
  endtask

  task automatic program_all();
    cfg_write(2'd0, 2'd0, BP0, 1'b0); cfg_write(2'd0, 2'd1, BP1, 1'b0); cfg_write(2'd0, 2'd2, BP2, 1'b0);
    cfg_write(2'd1, 2'd0, A0, 1'b0);  cfg_write(2'd1, 2'd1, A1, 1'b0);  cfg_write(2'd1, 2'd2, A2, 1'b0);
    cfg_write(2'd2, 2'd0, P0, 1'b0);  cfg_write(2'd2, 2'd1, P1, 1'b0);  cfg_write(2'd2, 2'd2, P2, 1'b0);
    cfg_write(2'd3, 2'd0, N0, 1'b0);  cfg_write(2'd3, 2'd1, N1, 1'b0);  cfg_write(2'd3, 2'd2, N2, 1'b0);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Entered and left on a falling edge with the DUT in IDLE.
  task automatic run_txn(input vec_t e, input int hold);
    int lat;
    logic [31:0] ha, hb;
    check("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; x_in = e.x; out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0; x_in = $urandom;
    check("in_ready_busy", {31'b0, in_ready}, 32'd0);
    wait_out(lat);
    check("latency", lat, e.lat);
    check("factor_a", factor_a, e.a);
    check("factor_b", factor_b, e.b);
    check("seg_idx", {30'b0, seg_idx}, {30'b0, e.seg});
    check("neg", {31'b0, neg}, {31'b0, e.neg});
    check("nan", {31'b0, nan}, {31'b0, e.nan});
    ha = factor_a; hb = factor_b;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      check("hold_a", factor_a, ha);
      check("hold_b", factor_b, hb);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("valid_drop", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    vec_t e;
    int lat;
    int quiet;
    logic [31:0] x;
    logic [31:0] xs;

    vecs[0] = '{x: 32'h3F000000, seg: 2'd0, a: A0,    b: P0,           neg: 1'b0, nan: 1'b0, lat: 1};
    vecs[1] = '{x: 32'hC0400000, seg: 2'd2, a: A2,    b: N2,           neg: 1'b1, nan: 1'b0, lat: 3};
    vecs[2] = '{x: 32'h40C00000, seg: 2'd3, a: 32'h0, b: 32'h3F800000, neg: 1'b0, nan: 1'b0, lat: 3};
    vecs[3] = '{x: 32'hC0C00000, seg: 2'd3, a: 32'h0, b: 32'h0,        neg: 1'b1, nan: 1'b0, lat: 3};
    vecs[4] = '{x: 32'h40133333, seg: 2'd2, a: A2,    b: P2,           neg: 1'b0, nan: 1'b0, lat: 3};
    vecs[5] = '{x: 32'h80000000, seg: 2'd0, a: A0,    b: P0,           neg: 1'b0, nan: 1'b0, lat: 1};
    vecs[6] = '{x: 32'h7FC00000, seg: 2'd3, a: 32'h0, b: 32'h0,        neg: 1'b0, nan: 1'b1, lat: 1};
    vecs[7] = '{x: 32'hBF800000, seg: 2'd1, a: A1,    b: N1,           neg: 1'b1, nan: 1'b0, lat: 2};

    for (int i = 0; i < NSEG - 1; i++) begin
      m_bp[i] = 0; m_a[i] = 0; m_bpos[i] = 0; m_bneg[i] = 0;
    end

    rst_n = 1'b0; in_valid = 1'b0; x_in = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_factor_a", factor_a, 32'h0);
    check("rst_factor_b", factor_b, 32'h0);
    check("rst_seg_idx", {30'b0, seg_idx}, 32'd0);
    check("rst_neg_nan_err", {29'b0, neg, nan, cfg_err}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    program_all();
    cfg_write(2'd1, 2'd3, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    check("cfg_err_pulse_end", {31'b0, cfg_err}, 32'd0);

    for (int i = 0; i < 8; i++) run_txn(vecs[i], 0);

    run_txn(vecs[1], 5);

    // Table write while a search is in flight must be rejected.
    in_valid = 1'b1; x_in = 32'hC0400000;
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_addr = 2'd0; cfg_data = 32'hDEADBEEF;
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_err_scan", {31'b0, cfg_err}, 32'd1);
    @(negedge clk);
    check("cfg_err_scan_end", {31'b0, cfg_err}, 32'd0);
    wait_out(lat);
    check("scan_wr_a", factor_a, A2);
    @(negedge clk);
    run_txn(vecs[0], 0);

    // Input and write together in IDLE: input wins, write is dropped.
    in_valid = 1'b1; x_in = 32'h3F000000;
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_addr = 2'd0; cfg_data = 32'h12345678;
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
    check("cfg_err_collide", {31'b0, cfg_err}, 32'd1);
    wait_out(lat);
    check("collide_b", factor_b, P0);
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        8: begin
          xs = m_bp[$urandom_range(0, NSEG - 2)];
          x  = {1'($urandom_range(0, 1)), xs[30:0]};
        end
        9: begin
          case ($urandom_range(0, 3))
            0: x = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 8388607))};
            1: x = {1'($urandom_range(0, 1)), 8'hFF, 23'h0};
            2: x = {1'($urandom_range(0, 1)), 31'h0};
            default: x = $urandom;
          endcase
        end
        default: x = {1'($urandom_range(0, 1)), 8'($urandom_range(8'h7D, 8'h82)), 23'($urandom)};
      endcase
      e = model(x);
      run_txn(e, $urandom_range(0, 2));
    end

    // Reset in the middle of a search aborts it and wipes the tables.
    in_valid = 1'b1; x_in = 32'hC0400000;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_a", factor_a, 32'h0);
    check("midrst_b", factor_b, 32'h0);
    check("midrst_seg_neg_nan", {27'b0, seg_idx, neg, nan, cfg_err}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < NSEG - 1; i++) begin
      m_bp[i] = 0; m_a[i] = 0; m_bpos[i] = 0; m_bneg[i] = 0;
    end
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) quiet++;
    end
    check("no_stale_output", quiet, 32'd0);
    e = model(32'h3F000000);
    check("model_cleared_seg", {30'b0, e.seg}, 32'd3);
    run_txn(e, 0);

    program_all();
    run_txn(vecs[1], 0);
    quiet = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid) quiet++;
    end
    check("single_result", quiet, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
